mem_port_scheduler: RTL and testbench

Sequencer that shares one single-ported unified instruction/data memory between the IF stage and the MEM stage of the 5-stage pipeline. Data accesses take priority over instruction fetches. The block drives the memory request handshake and owns a one-entry fetched-instruction buffer. It generates the stall controls that freeze the PC and pipeline registers while the port is busy.

---
 rtl/mem_sched_pkg.sv | 30 +++
 rtl/mem_port_scheduler_fetch_buf.sv | 44 ++++
 rtl/mem_port_scheduler.sv | 134 +++++++++++++
 tb/tb_mem_port_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared encodings for the unified memory port scheduler.
// Holds the FSM states, the request types and the arbitration rule.
package mem_sched_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_FETCH = 2'd1,
        REQ_DATA  = 2'd2
    } req_t;

    // Data always wins; a fetch is only worth starting into an empty buffer.
    function automatic req_t arbitrate(input logic d_req, input logic if_req,
                                       input logic buf_empty);
        req_t r;
        r = REQ_NONE;
        if (d_req) begin
            r = REQ_DATA;
        end else if (if_req && buf_empty) begin
            r = REQ_FETCH;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_port_scheduler_fetch_buf.sv
// One-entry fetched-instruction register with kill handling.
// The drop flag marks an in-flight fetch whose result must be thrown away.
module fetch_buf #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              consume,
    input  logic              kill,
    input  logic              fetch_busy,
    input  logic [DATA_W-1:0] load_data,
    output logic              buf_valid,
    output logic [DATA_W-1:0] buf_inst,
    output logic              drop
);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_inst  <= '0;
            drop      <= 1'b0;
        end else begin
            // Kill beats a same-cycle load; a pending drop swallows the load.
            if (kill) begin
                buf_valid <= 1'b0;
            end else if (load && !drop) begin
                buf_valid <= 1'b1;
                buf_inst  <= load_data;
            end else if (consume) begin
                buf_valid <= 1'b0;
            end

            // A kill at completion is handled by the load gate above, so
            // completion always retires the flag.
            if (load) begin
                drop <= 1'b0;
            end else if (kill && fetch_busy) begin
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// Arbitrates one single-ported I/D memory between IF and MEM stages.
// Data has priority; an in-flight fetch always runs to completion.
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_inst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_pipe,
    output logic              stall_if,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    logic [ST_W-1:0]   state, state_nxt;
    logic              mem_req_nxt, mem_we_nxt, d_valid_nxt, do_arb;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt, d_rdata_nxt;
    logic              fetch_done_c, drop, d_req_eff_c, buf_empty_c;
    req_t              req_c;

    assign stall_pipe   = d_req & ~d_valid;
    assign stall_if     = ~if_valid & ~stall_pipe;
    assign fetch_done_c = (state == ST_FETCH) & mem_ready;

    // d_req stays high through its own completion; don't issue it twice.
    assign d_req_eff_c  = d_req & ~d_valid & ~((state == ST_DATA) & mem_ready);
    assign buf_empty_c  = (~if_valid | if_kill) & ~(fetch_done_c & ~drop & ~if_kill);
    assign req_c        = arbitrate(d_req_eff_c, if_req, buf_empty_c);

    fetch_buf #(.DATA_W(DATA_W)) u_fetch_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (fetch_done_c),
        .consume    (if_valid & ~stall_pipe),
        .kill       (if_kill),
        .fetch_busy (state == ST_FETCH),
        .load_data  (mem_rdata),
        .buf_valid  (if_valid),
        .buf_inst   (if_inst),
        .drop       (drop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            d_valid   <= d_valid_nxt;
            d_rdata   <= d_rdata_nxt;
        end
    end

    // Completion and re-arbitration share a cycle so accesses run back to back.
    always_comb begin
        state_nxt     = state;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        d_valid_nxt   = 1'b0;
        d_rdata_nxt   = d_rdata;
        do_arb        = 1'b0;

        case (state)
            ST_IDLE:  do_arb = 1'b1;
            ST_FETCH: do_arb = mem_ready;
            ST_DATA: begin
                do_arb = mem_ready;
                if (mem_ready) begin
                    d_valid_nxt = 1'b1;
                    if (!mem_we) begin
                        d_rdata_nxt = mem_rdata;
                    end
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase

        if (do_arb) begin
            case (req_c)
                REQ_DATA: begin
                    state_nxt     = ST_DATA;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                end
                REQ_FETCH: begin
                    state_nxt    = ST_FETCH;
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = if_addr;
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Scoreboard bench for mem_port_scheduler: directed stimulus pushes expected
// memory transactions, data returns and fetched instructions into queues.
module tb_mem_port_scheduler;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, if_valid;
    logic [31:0] if_addr, if_inst;
    logic        d_req, d_we, d_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        stall_pipe, stall_if;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 0;
    int          late_req = 0;

    mem_txn_t    exp_mem[$];
    logic [31:0] exp_d[$];
    logic [31:0] exp_if[$];
    logic [31:0] mem_arr[logic [31:0]];

    mem_port_scheduler #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_valid(if_valid), .if_inst(if_inst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .stall_pipe(stall_pipe), .stall_if(stall_if),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: output seen, nothing expected", name);
    endfunction

    function automatic void push_mem(input logic we, input logic [31:0] a,
                                     input logic [31:0] wd);
        mem_txn_t t;
        t.we = we; t.addr = a; t.wdata = wd;
        exp_mem.push_back(t);
    endfunction

    // Memory responder: mem_ready in the (lat)th cycle after mem_req rises.
    initial begin
        int cnt;
        int late_done;
        cnt = 0; late_done = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        mem_arr[32'h40] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (late_req != late_done) begin
                late_done = late_req;
                mem_ready = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end else if (mem_req) begin
                if (cnt == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_we ? 32'hFFFF_FFFF : mem_read(mem_addr);
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        logic        act;
        logic        f_we;
        logic [31:0] f_addr, f_wdata;
        mem_txn_t    e;
        act = 1'b0; f_we = 1'b0; f_addr = '0; f_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0;
                continue;
            end
            if (mem_req) begin
                if (!act) begin
                    f_we = mem_we; f_addr = mem_addr; f_wdata = mem_wdata;
                    act = 1'b1;
                end
                if (mem_ready) begin
                    chk("mem_addr_stable", mem_addr, f_addr);
                    chk("mem_we_stable", 32'(mem_we), 32'(f_we));
                    chk("mem_wdata_stable", mem_wdata, f_wdata);
                    if (exp_mem.size() == 0) begin
                        unexpected("mem_txn");
                    end else begin
                        e = exp_mem.pop_front();
                        chk("mem_we", 32'(mem_we), 32'(e.we));
                        chk("mem_addr", mem_addr, e.addr);
                        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    end
                    act = 1'b0;
                end
            end else begin
                act = 1'b0;
            end
            if (d_valid) begin
                if (exp_d.size() == 0) unexpected("d_valid");
                else chk("d_rdata", d_rdata, exp_d.pop_front());
            end
            if (if_valid && !stall_pipe) begin
                if (exp_if.size() == 0) unexpected("if_valid");
                else chk("if_inst", if_inst, exp_if.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        logic [31:0] prev_rdata;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset state
        tick(); tick(); settle();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_stall_if", 32'(stall_if), 32'd1);
        d_req = 1'b1; #1;
        chk("rst_stall_pipe", 32'(stall_pipe), 32'd1);
        chk("rst_stall_if_pipe", 32'(stall_if), 32'd0);
        d_req = 1'b0;
        tick(); rst = 1'b0;

        // Load after reset, W=0
        tick(); lat = 0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        push_mem(1'b0, 32'h40, 32'h0); exp_d.push_back(32'hDEAD_BEEF);
        settle();
        chk("t1_c0_stall", 32'(stall_pipe), 32'd1);
        chk("t1_c0_mem_req", 32'(mem_req), 32'd0);
        tick(); settle();
        chk("t1_c1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_c1_stall", 32'(stall_pipe), 32'd1);
        tick(); settle();
        chk("t1_c2_d_valid", 32'(d_valid), 32'd1);
        chk("t1_c2_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("t1_c2_stall", 32'(stall_pipe), 32'd0);
        tick(); d_req = 1'b0; settle();
        chk("t1_c3_no_reissue", 32'(mem_req), 32'd0);
        chk("t1_c3_d_valid", 32'(d_valid), 32'd0);

        // Contention: data arrives during a W=3 fetch
        tick(); lat = 3; if_req = 1'b1; if_addr = 32'h100;
        push_mem(1'b0, 32'h100, 32'h0); exp_if.push_back(mem_read(32'h100));
        tick(); if_req = 1'b0; settle();
        chk("t2_c1_fetch_addr", mem_addr, 32'h100);
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        push_mem(1'b0, 32'h200, 32'h0); exp_d.push_back(mem_read(32'h200));
        settle();
        chk("t2_c2_stall_pipe", 32'(stall_pipe), 32'd1);
        chk("t2_c2_stall_if", 32'(stall_if), 32'd0);
        tick(); settle();
        chk("t2_c3_fetch_kept", mem_addr, 32'h100);
        tick(); tick(); settle();
        chk("t2_c5_mem_req", 32'(mem_req), 32'd1);
        chk("t2_c5_data_addr", mem_addr, 32'h200);
        chk("t2_c5_if_valid", 32'(if_valid), 32'd1);
        chk("t2_c5_if_inst", if_inst, mem_read(32'h100));
        tick(); tick(); tick(); settle();
        chk("t2_c8_if_hold", 32'(if_valid), 32'd1);
        tick(); settle();
        chk("t2_c9_d_valid", 32'(d_valid), 32'd1);
        chk("t2_c9_stall", 32'(stall_pipe), 32'd0);
        tick(); d_req = 1'b0; settle();
        chk("t2_c10_if_valid", 32'(if_valid), 32'd0);
        chk("t2_c10_stall_if", 32'(stall_if), 32'd1);

        // Simultaneous d_req and if_req, W=0
        tick(); lat = 0; d_req = 1'b1; d_addr = 32'h44; if_req = 1'b1; if_addr = 32'h104;
        push_mem(1'b0, 32'h44, 32'h0); push_mem(1'b0, 32'h104, 32'h0);
        exp_d.push_back(mem_read(32'h44)); exp_if.push_back(mem_read(32'h104));
        settle();
        chk("t3_c0_stall_if", 32'(stall_if), 32'd0);
        tick(); settle();
        chk("t3_c1_data_first", mem_addr, 32'h44);
        chk("t3_c1_stall_if", 32'(stall_if), 32'd0);
        tick(); settle();
        chk("t3_c2_d_valid", 32'(d_valid), 32'd1);
        chk("t3_c2_fetch_addr", mem_addr, 32'h104);
        chk("t3_c2_fetch_req", 32'(mem_req), 32'd1);
        tick(); d_req = 1'b0; if_req = 1'b0; settle();
        chk("t3_c3_if_valid", 32'(if_valid), 32'd1);
        tick(); settle();
        chk("t3_c4_if_valid", 32'(if_valid), 32'd0);
        chk("t3_c4_mem_req", 32'(mem_req), 32'd0);

        // if_kill in the mem_ready cycle of a fetch, W=2
        tick(); lat = 2; if_req = 1'b1; if_addr = 32'h108;
        push_mem(1'b0, 32'h108, 32'h0);
        tick(); tick();
        tick(); if_kill = 1'b1; if_addr = 32'h300;
        push_mem(1'b0, 32'h300, 32'h0); exp_if.push_back(mem_read(32'h300));
        tick(); if_kill = 1'b0; if_req = 1'b0; settle();
        chk("t4_c4_if_valid", 32'(if_valid), 32'd0);
        chk("t4_c4_new_addr", mem_addr, 32'h300);
        chk("t4_c4_mem_req", 32'(mem_req), 32'd1);
        tick(); tick();
        tick(); settle();
        chk("t4_c7_if_valid", 32'(if_valid), 32'd1);
        tick(); settle();
        chk("t4_c8_if_valid", 32'(if_valid), 32'd0);

        // if_kill mid-fetch sets drop; next fetch is kept
        tick(); if_req = 1'b1; if_addr = 32'h10C;
        push_mem(1'b0, 32'h10C, 32'h0);
        tick(); if_req = 1'b0;
        tick(); if_kill = 1'b1;
        tick(); if_kill = 1'b0;
        tick(); if_req = 1'b1; if_addr = 32'h110;
        push_mem(1'b0, 32'h110, 32'h0); exp_if.push_back(mem_read(32'h110));
        settle();
        chk("t4b_c4_dropped", 32'(if_valid), 32'd0);
        tick(); if_req = 1'b0; settle();
        chk("t4b_c5_addr", mem_addr, 32'h110);
        tick(); tick();
        tick(); settle();
        chk("t4b_c8_if_valid", 32'(if_valid), 32'd1);
        tick(); settle();
        chk("t4b_c9_if_valid", 32'(if_valid), 32'd0);

        // Store, W=1: d_rdata keeps the last load value
        prev_rdata = mem_read(32'h44);
        tick(); lat = 1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
        push_mem(1'b1, 32'h80, 32'h1234_5678); exp_d.push_back(prev_rdata);
        tick(); settle();
        chk("t5_c1_mem_we", 32'(mem_we), 32'd1);
        chk("t5_c1_wdata", mem_wdata, 32'h1234_5678);
        tick(); settle();
        chk("t5_c2_mem_we", 32'(mem_we), 32'd1);
        chk("t5_c2_d_valid", 32'(d_valid), 32'd0);
        tick(); settle();
        chk("t5_c3_d_valid", 32'(d_valid), 32'd1);
        chk("t5_c3_d_rdata", d_rdata, prev_rdata);
        tick(); d_req = 1'b0; d_we = 1'b0; settle();
        chk("t5_c4_d_valid", 32'(d_valid), 32'd0);
        chk("t5_c4_mem_req", 32'(mem_req), 32'd0);

        // Reset during a W=5 data access; late mem_ready ignored
        tick(); lat = 5; d_req = 1'b1; d_addr = 32'h48;
        tick(); settle();
        chk("t6_c1_mem_req", 32'(mem_req), 32'd1);
        tick(); rst = 1'b1; d_req = 1'b0;
        tick(); rst = 1'b0; settle();
        chk("t6_c3_mem_req", 32'(mem_req), 32'd0);
        chk("t6_c3_d_valid", 32'(d_valid), 32'd0);
        chk("t6_c3_d_rdata", d_rdata, 32'd0);
        tick(); late_req++;
        tick(); settle();
        chk("t6_c5_d_valid", 32'(d_valid), 32'd0);
        chk("t6_c5_mem_req", 32'(mem_req), 32'd0);
        chk("t6_c5_d_rdata", d_rdata, 32'd0);
        repeat (3) tick();

        chk("left_mem_txn", 32'(exp_mem.size()), 32'd0);
        chk("left_d_resp", 32'(exp_d.size()), 32'd0);
        chk("left_if_inst", 32'(exp_if.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
